pipeline_hazard_ctrl: RTL
=========================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL provide parameter: FPU_TIMEOUT, 64, max FPU_WAIT cycles before forced release (range 2..255).
REQ-002 SHALL provide the following ports, clock and reset first:
- CLK  in  1  single clock; all state changes on posedge.
- RESET  in  1  asynchronous, active-low reset.
- ID_REG_READ_ADDR1/2/3  in  5 each  source addresses of the instruction in ID.
- EX_REG_WRITE_ADDR  in  5  destination address of the instruction in EX.
- EX_REG_WRITE_EN, EX_FREG_WRITE_EN  in  1 each  integer / float write enables in EX.
- EX_DATA_MEM_READ  in  4  load type in EX; nonzero = load.
- EX_NET_READ, EX_NET_WRITE  in  1 each  network read / write in EX.
- EX_FPU_SELECT  in  5  FPU op in EX; nonzero = multi-cycle FPU op.
- FPU_DONE  in  1  FPU result valid this cycle.
- NET_READY  in  1  network interface accepts the write this cycle.
- BRANCH_TAKEN  in  1  EX resolved a taken branch or jump.
- CNT_CLEAR  in  1  synchronous clear of STALL_CYCLES.
- PC_STALL, IF_ID_STALL, ID_EX_STALL  out  1 each  hold PC / IF-ID / ID-EX registers.
- IF_ID_FLUSH, ID_EX_FLUSH  out  1 each  load a bubble (all-zero controls) next edge.
- STALL_CYCLES  out  16  saturating count of cycles with PC_STALL=1.
- TIMEOUT_ERR  out  1  sticky; set on FPU timeout.

Function
REQ-003 SHALL implement FSM states RUN, FPU_WAIT, NET_WAIT; stall/flush outputs combinational from state and inputs; state, counters, TIMEOUT_ERR registered.
REQ-004 SHALL define load_use = (EX_DATA_MEM_READ!=0 or EX_NET_READ) and ((EX_REG_WRITE_EN and EX_REG_WRITE_ADDR!=0 and addr equals ID addr1 or addr2) or (EX_FREG_WRITE_EN and addr equals ID addr1, addr2 or addr3)).
REQ-005 In RUN, SHALL apply the first true condition, in priority order:
- BRANCH_TAKEN: IF_ID_FLUSH=ID_EX_FLUSH=1, no stalls, stay RUN.
- EX_FPU_SELECT!=0 and !FPU_DONE: all three stalls=1, go FPU_WAIT, wait counter=1.
- EX_NET_WRITE and !NET_READY: all three stalls=1, go NET_WAIT.
- load_use: PC_STALL=IF_ID_STALL=ID_EX_FLUSH=1, ID_EX_STALL=0, stay RUN.
- otherwise: all outputs 0.
REQ-006 In FPU_WAIT, SHALL hold all three stalls=1 while !FPU_DONE and wait counter<FPU_TIMEOUT, incrementing the counter each cycle.
REQ-007 In FPU_WAIT, SHALL drop all stalls combinationally in the cycle FPU_DONE=1 and return to RUN next edge.
REQ-008 In FPU_WAIT, SHALL on counter reaching FPU_TIMEOUT without FPU_DONE drop all stalls, set TIMEOUT_ERR, and return to RUN.
REQ-009 In NET_WAIT, SHALL hold all stalls=1 until NET_READY=1; in that cycle stalls=0, and return to RUN next edge. No timeout applies.
REQ-010 SHALL ignore BRANCH_TAKEN in FPU_WAIT and NET_WAIT, since EX holds a non-branch op.
REQ-011 SHALL never assert IF_ID_FLUSH and IF_ID_STALL together.
REQ-012 SHALL never assert ID_EX_FLUSH and ID_EX_STALL together.
REQ-013 SHALL increment STALL_CYCLES each cycle PC_STALL=1, saturating at 16'hFFFF. CNT_CLEAR has priority and loads 0.
REQ-014 Once set, TIMEOUT_ERR SHALL clear only on reset.

Reset
REQ-015 While RESET=0, SHALL force all of the following immediately, independent of CLK: state=RUN, wait counter=0, STALL_CYCLES=0, TIMEOUT_ERR=0, all stall/flush outputs 0.
REQ-016 RESET low mid-FPU_WAIT or mid-NET_WAIT SHALL abort the wait. The first edge after release SHALL evaluate RUN rules.

Verification
REQ-017 Load then use: EX_DATA_MEM_READ=4'd2, EX_REG_WRITE_EN=1, EX_REG_WRITE_ADDR=5, ID addr2=5 -> exactly one cycle of PC_STALL=IF_ID_STALL=ID_EX_FLUSH=1; STALL_CYCLES=1. Same case with write addr 0 -> no stall.
REQ-018 FPU op: EX_FPU_SELECT=5'd3, FPU_DONE rises 4 cycles later -> stalls high 4 cycles, low in the DONE cycle; STALL_CYCLES=4; state RUN.
REQ-019 FPU timeout: FPU_TIMEOUT=8, FPU_DONE held 0 -> stalls high 8 cycles, then released; TIMEOUT_ERR=1 and remains 1 afterwards.
REQ-020 Branch vs hazard: BRANCH_TAKEN=1 together with load_use -> IF_ID_FLUSH=ID_EX_FLUSH=1, PC_STALL=0.
REQ-021 Net wait with reset: EX_NET_WRITE=1, NET_READY=0 for 3 cycles, then RESET=0 between edges -> outputs drop to 0 immediately; STALL_CYCLES=0; after release, NET_READY=1 -> no stall.
REQ-022 Saturation and clear: hold the stall until STALL_CYCLES=16'hFFFF, then run more stall cycles -> value stays 16'hFFFF; assert CNT_CLEAR with a stall active -> 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
//   Groups the signals exchanged between the pipeline datapath and the hazard
//   controller. The datapath side uses the master modport; the hazard
//   controller uses the slave modport.
//
//   Datapath -> controller:
//     ID_REG_READ_ADDR1/2/3  source register addresses of the ID instruction
//     EX_REG_WRITE_ADDR      destination register of the EX instruction
//     EX_REG_WRITE_EN        integer register write enable in EX
//     EX_FREG_WRITE_EN       float register write enable in EX
//     EX_DATA_MEM_READ       load type in EX (nonzero means load)
//     EX_NET_READ            network read in EX (behaves like a load)
//     EX_NET_WRITE           network write in EX
//     EX_FPU_SELECT          FPU operation in EX (nonzero means multi-cycle)
//     FPU_DONE               FPU result valid this cycle
//     NET_READY              network interface accepts a write this cycle
//     BRANCH_TAKEN           EX resolved a taken branch or jump
//     CNT_CLEAR              synchronous clear of STALL_CYCLES
//   Controller -> datapath:
//     PC_STALL, IF_ID_STALL, ID_EX_STALL   hold the respective registers
//     IF_ID_FLUSH, ID_EX_FLUSH             load a bubble on the next edge
//     STALL_CYCLES                         saturating count of PC stall cycles
//     TIMEOUT_ERR                          sticky FPU timeout flag
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;
    logic [4:0]  ID_REG_READ_ADDR1;
    logic [4:0]  ID_REG_READ_ADDR2;
    logic [4:0]  ID_REG_READ_ADDR3;
    logic [4:0]  EX_REG_WRITE_ADDR;
    logic        EX_REG_WRITE_EN;
    logic        EX_FREG_WRITE_EN;
    logic [3:0]  EX_DATA_MEM_READ;
    logic        EX_NET_READ;
    logic        EX_NET_WRITE;
    logic [4:0]  EX_FPU_SELECT;
    logic        FPU_DONE;
    logic        NET_READY;
    logic        BRANCH_TAKEN;
    logic        CNT_CLEAR;
    logic        PC_STALL;
    logic        IF_ID_STALL;
    logic        ID_EX_STALL;
    logic        IF_ID_FLUSH;
    logic        ID_EX_FLUSH;
    logic [15:0] STALL_CYCLES;
    logic        TIMEOUT_ERR;

    modport master (
        output ID_REG_READ_ADDR1, ID_REG_READ_ADDR2, ID_REG_READ_ADDR3,
        output EX_REG_WRITE_ADDR, EX_REG_WRITE_EN, EX_FREG_WRITE_EN,
        output EX_DATA_MEM_READ, EX_NET_READ, EX_NET_WRITE, EX_FPU_SELECT,
        output FPU_DONE, NET_READY, BRANCH_TAKEN, CNT_CLEAR,
        input  PC_STALL, IF_ID_STALL, ID_EX_STALL, IF_ID_FLUSH, ID_EX_FLUSH,
        input  STALL_CYCLES, TIMEOUT_ERR
    );

    modport slave (
        input  ID_REG_READ_ADDR1, ID_REG_READ_ADDR2, ID_REG_READ_ADDR3,
        input  EX_REG_WRITE_ADDR, EX_REG_WRITE_EN, EX_FREG_WRITE_EN,
        input  EX_DATA_MEM_READ, EX_NET_READ, EX_NET_WRITE, EX_FPU_SELECT,
        input  FPU_DONE, NET_READY, BRANCH_TAKEN, CNT_CLEAR,
        output PC_STALL, IF_ID_STALL, ID_EX_STALL, IF_ID_FLUSH, ID_EX_FLUSH,
        output STALL_CYCLES, TIMEOUT_ERR
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Hazard controller for an in-order pipeline. Detects load-use hazards,
//   waits out multi-cycle FPU operations (with a forced release after
//   FPU_TIMEOUT cycles) and blocked network writes, and flushes the front of
//   the pipe on a taken branch. Stall/flush outputs are combinational from
//   the FSM state and the current inputs; state, counters and the timeout
//   flag are registered.
//
//   Parameters:
//     FPU_TIMEOUT  maximum FPU wait count before forced release (2..255)
//   Ports:
//     CLK    clock, all state changes on the rising edge
//     RESET  asynchronous active-low reset
//     hz     slave side of pipeline_hazard_ctrl_if (see interface header)
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int FPU_TIMEOUT = 64
) (
    input  logic                   CLK,
    input  logic                   RESET,
    pipeline_hazard_ctrl_if.slave  hz
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FPU_WAIT = 2'd1,
        NET_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(FPU_TIMEOUT);

    state_t      state;
    state_t      next_state;
    logic [7:0]  wait_cnt;
    logic [7:0]  next_cnt;
    logic        timeout_hit;
    logic [15:0] stall_cnt;
    logic        timeout_err;

    logic        ex_is_load;
    logic        int_hit;
    logic        fp_hit;
    logic        load_use;

    logic        pc_stall;
    logic        if_id_stall;
    logic        id_ex_stall;
    logic        if_id_flush;
    logic        id_ex_flush;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Integer register 0 is hard-wired, so a write to it never creates a
    // dependency; float register 0 is a real register and is not excluded.
    // Only float ops read the third source port.
    always_comb begin
        ex_is_load = (hz.EX_DATA_MEM_READ != 4'd0) || hz.EX_NET_READ;
        int_hit    = hz.EX_REG_WRITE_EN && (hz.EX_REG_WRITE_ADDR != 5'd0) &&
                     ((hz.EX_REG_WRITE_ADDR == hz.ID_REG_READ_ADDR1) ||
                      (hz.EX_REG_WRITE_ADDR == hz.ID_REG_READ_ADDR2));
        fp_hit     = hz.EX_FREG_WRITE_EN &&
                     ((hz.EX_REG_WRITE_ADDR == hz.ID_REG_READ_ADDR1) ||
                      (hz.EX_REG_WRITE_ADDR == hz.ID_REG_READ_ADDR2) ||
                      (hz.EX_REG_WRITE_ADDR == hz.ID_REG_READ_ADDR3));
        load_use   = ex_is_load && (int_hit || fp_hit);
    end

    always_comb begin
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        id_ex_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        next_state  = state;
        next_cnt    = wait_cnt;
        timeout_hit = 1'b0;

        case (state)
            RUN: begin
                if (hz.BRANCH_TAKEN) begin
                    // Wrong-path instructions in IF/ID and ID/EX are discarded;
                    // any hazard they carried no longer matters.
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if ((hz.EX_FPU_SELECT != 5'd0) && !hz.FPU_DONE) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_stall = 1'b1;
                    next_state  = FPU_WAIT;
                    next_cnt    = 8'd1;
                end else if (hz.EX_NET_WRITE && !hz.NET_READY) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_stall = 1'b1;
                    next_state  = NET_WAIT;
                end else if (load_use) begin
                    // Hold the consumer in ID and let the load advance,
                    // inserting a bubble into EX behind it.
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end
            end

            FPU_WAIT: begin
                if (hz.FPU_DONE) begin
                    next_state = RUN;
                    next_cnt   = 8'd0;
                end else if (wait_cnt < TIMEOUT_LIM) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_stall = 1'b1;
                    next_cnt    = wait_cnt + 8'd1;
                end else begin
                    // Forced release: the FPU never answered.
                    timeout_hit = 1'b1;
                    next_state  = RUN;
                    next_cnt    = 8'd0;
                end
            end

            NET_WAIT: begin
                if (hz.NET_READY) begin
                    next_state = RUN;
                end else begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_stall = 1'b1;
                end
            end

            default: begin
                next_state = RUN;
                next_cnt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= RUN;
            wait_cnt    <= 8'd0;
            stall_cnt   <= 16'd0;
            timeout_err <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_cnt;
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
            if (hz.CNT_CLEAR) begin
                stall_cnt <= 16'd0;
            end else if (pc_stall) begin
                stall_cnt <= sat_inc16(stall_cnt);
            end
        end
    end

    // RUN decisions depend on live inputs, so the outputs are gated by the
    // reset itself to be quiet immediately while reset is held.
    assign hz.PC_STALL     = RESET & pc_stall;
    assign hz.IF_ID_STALL  = RESET & if_id_stall;
    assign hz.ID_EX_STALL  = RESET & id_ex_stall;
    assign hz.IF_ID_FLUSH  = RESET & if_id_flush;
    assign hz.ID_EX_FLUSH  = RESET & id_ex_flush;
    assign hz.STALL_CYCLES = stall_cnt;
    assign hz.TIMEOUT_ERR  = timeout_err;

endmodule
